// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared screen constants, player state encoding and HP helpers
package game_pkg;

    localparam int X_LAST  = 639;   // last active x coordinate
    localparam int Y_LAST  = 479;   // last active y coordinate
    localparam int COORD_W = 10;    // raster coordinate width
    localparam int HP_W    = 8;     // hit point register width

    typedef enum logic [1:0] {
        ALIVE,
        INVULN,
        DEAD
    } state_t;

    // Saturating unsigned subtract: damage larger than the remaining HP floors at 0.
    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a,
                                                input logic [HP_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/bullet_hit_detector_if.sv
// rtl/bullet_hit_detector_if.sv - raster/sprite inputs and player status outputs of the hit detector
// master: sprite/raster side (drives xx, yy, aactive, heart_on, bullet_on; reads status)
// slave : hit detector (reads pixel stream; drives hp, hit_pulse, hit_mask, invuln, heart_visible, game_over)
interface bullet_hit_detector_if #(
    parameter int N_BULLETS = 4
) ();
    import game_pkg::*;

    logic [COORD_W-1:0]   xx;
    logic [COORD_W-1:0]   yy;
    logic                 aactive;
    logic                 heart_on;
    logic [N_BULLETS-1:0] bullet_on;

    logic [HP_W-1:0]      hp;
    logic                 hit_pulse;
    logic [N_BULLETS-1:0] hit_mask;
    logic                 invuln;
    logic                 heart_visible;
    logic                 game_over;

    modport master (
        output xx, yy, aactive, heart_on, bullet_on,
        input  hp, hit_pulse, hit_mask, invuln, heart_visible, game_over
    );

    modport slave (
        input  xx, yy, aactive, heart_on, bullet_on,
        output hp, hit_pulse, hit_mask, invuln, heart_visible, game_over
    );
endinterface

// File: rtl/frame_tick.sv
// rtl/frame_tick.sv - one-cycle frame_end strobe on the pixel-delayed raster position
// Ports: Pclk, rst_n (sync active-low); xx/yy/aactive raw raster position;
//        aactive_d delayed active flag; frame_end high while the delayed position is (X_END, Y_END).
module frame_tick
    import game_pkg::*;
#(
    parameter int X_END = X_LAST,
    parameter int Y_END = Y_LAST
) (
    input  logic               Pclk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] xx,
    input  logic [COORD_W-1:0] yy,
    input  logic               aactive,
    output logic               aactive_d,
    output logic               frame_end
);
    logic [COORD_W-1:0] xx_d;
    logic [COORD_W-1:0] yy_d;

    // One stage of delay so the position lines up with the registered sprite flags.
    always_ff @(posedge Pclk) begin
        if (!rst_n) begin
            xx_d      <= '0;
            yy_d      <= '0;
            aactive_d <= 1'b0;
        end else begin
            xx_d      <= xx;
            yy_d      <= yy;
            aactive_d <= aactive;
        end
    end

    assign frame_end = (xx_d == COORD_W'(X_END)) && (yy_d == COORD_W'(Y_END));

endmodule

// File: rtl/bullet_hit_detector.sv
// rtl/bullet_hit_detector.sv - heart/bullet overlap detection, HP, invulnerability blink and game over
// Ports: Pclk, rst_n (sync active-low); bus (slave): pixel position, heart_on, bullet_on in;
//        hp, hit_pulse, hit_mask, invuln, heart_visible, game_over out.
module bullet_hit_detector #(
    parameter int N_BULLETS     = 4,
    parameter int HP_INIT       = 20,
    parameter int DAMAGE        = 3,
    parameter int INVULN_FRAMES = 60,
    parameter int BLINK_FRAMES  = 4,
    parameter int X_LAST        = game_pkg::X_LAST,
    parameter int Y_LAST        = game_pkg::Y_LAST
) (
    input  logic                   Pclk,
    input  logic                   rst_n,
    bullet_hit_detector_if.slave   bus
);
    import game_pkg::HP_W;
    import game_pkg::state_t;
    import game_pkg::ALIVE;
    import game_pkg::INVULN;
    import game_pkg::DEAD;
    import game_pkg::sat_sub;

    localparam int CNT_W = $clog2(INVULN_FRAMES + 1);
    localparam int BLK_W = $clog2(BLINK_FRAMES + 1);

    logic aactive_d;
    logic frame_end;

    frame_tick #(
        .X_END (X_LAST),
        .Y_END (Y_LAST)
    ) u_frame_tick (
        .Pclk      (Pclk),
        .rst_n     (rst_n),
        .xx        (bus.xx),
        .yy        (bus.yy),
        .aactive   (bus.aactive),
        .aactive_d (aactive_d),
        .frame_end (frame_end)
    );

    state_t               state, state_nx;
    logic [HP_W-1:0]      hp_q, hp_nx;
    logic                 pulse_q, pulse_nx;
    logic                 vis_q, vis_nx;
    logic [CNT_W-1:0]     cnt_q, cnt_nx;
    logic [BLK_W-1:0]     blk_q, blk_nx;
    logic [N_BULLETS-1:0] acc_mask, hit_mask_q;
    logic [N_BULLETS-1:0] pix_mask, frame_mask;

    // The frame-end pixel itself still counts toward the frame it closes.
    assign pix_mask   = bus.bullet_on & {N_BULLETS{bus.heart_on & aactive_d}};
    assign frame_mask = acc_mask | pix_mask;

    always_comb begin
        state_nx = state;
        hp_nx    = hp_q;
        pulse_nx = 1'b0;
        vis_nx   = vis_q;
        cnt_nx   = cnt_q;
        blk_nx   = blk_q;
        if (frame_end) begin
            case (state)
                ALIVE: begin
                    if (|frame_mask) begin
                        hp_nx    = sat_sub(hp_q, HP_W'(DAMAGE));
                        pulse_nx = 1'b1;
                        blk_nx   = '0;
                        if (hp_nx == '0) begin
                            state_nx = DEAD;
                        end else begin
                            state_nx = INVULN;
                            cnt_nx   = CNT_W'(INVULN_FRAMES - 1);
                        end
                    end
                end
                INVULN: begin
                    // Expiry frame ignores collisions; damage resumes next frame.
                    if (cnt_q <= CNT_W'(1)) begin
                        state_nx = ALIVE;
                        cnt_nx   = '0;
                        vis_nx   = 1'b1;
                    end else begin
                        cnt_nx = cnt_q - CNT_W'(1);
                        // blk_q counts INVULN frame ends modulo BLINK_FRAMES.
                        if (blk_q == BLK_W'(BLINK_FRAMES - 1)) begin
                            blk_nx = '0;
                            vis_nx = ~vis_q;
                        end else begin
                            blk_nx = blk_q + BLK_W'(1);
                        end
                    end
                end
                DEAD: begin
                    vis_nx = 1'b1;
                end
                default: begin
                    state_nx = ALIVE;
                end
            endcase
        end
    end

    always_ff @(posedge Pclk) begin
        if (!rst_n) begin
            state      <= ALIVE;
            hp_q       <= HP_W'(HP_INIT);
            pulse_q    <= 1'b0;
            vis_q      <= 1'b1;
            cnt_q      <= '0;
            blk_q      <= '0;
            acc_mask   <= '0;
            hit_mask_q <= '0;
        end else begin
            state   <= state_nx;
            hp_q    <= hp_nx;
            pulse_q <= pulse_nx;
            vis_q   <= vis_nx;
            cnt_q   <= cnt_nx;
            blk_q   <= blk_nx;
            if (frame_end) begin
                acc_mask   <= '0;
                hit_mask_q <= frame_mask;
            end else begin
                acc_mask   <= frame_mask;
            end
        end
    end

    assign bus.hp            = hp_q;
    assign bus.hit_pulse     = pulse_q;
    assign bus.hit_mask      = hit_mask_q;
    assign bus.invuln        = (state == INVULN);
    assign bus.heart_visible = vis_q;
    assign bus.game_over     = (state == DEAD);

endmodule

// File: tb/tb_bullet_hit_detector.sv
// tb/tb_bullet_hit_detector.sv - randomized self-checking bench for bullet_hit_detector
module tb_bullet_hit_detector;
    localparam int NB  = 4;
    localparam int IFR = 60;
    localparam int BF  = 4;
    localparam int DMG = 3;

    logic Pclk = 1'b0;
    always #20 Pclk = ~Pclk;

    logic          rst_n;
    logic [9:0]    xx, yy;
    logic          aactive, heart_on;
    logic [NB-1:0] bullet_on;

    bullet_hit_detector_if #(.N_BULLETS(NB)) bus0 ();
    bullet_hit_detector_if #(.N_BULLETS(NB)) bus1 ();

    assign bus0.xx = xx;  assign bus0.yy = yy;  assign bus0.aactive = aactive;
    assign bus0.heart_on = heart_on;  assign bus0.bullet_on = bullet_on;
    assign bus1.xx = xx;  assign bus1.yy = yy;  assign bus1.aactive = aactive;
    assign bus1.heart_on = heart_on;  assign bus1.bullet_on = bullet_on;

    bullet_hit_detector #(.N_BULLETS(NB)) dut0 (.Pclk(Pclk), .rst_n(rst_n), .bus(bus0));
    bullet_hit_detector #(.N_BULLETS(NB), .HP_INIT(5)) dut1 (.Pclk(Pclk), .rst_n(rst_n), .bus(bus1));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: per-frame rules on frame numbers, not per-cycle state.
    int            hp_init [2] = '{20, 5};
    int            m_hp    [2];
    int            m_last  [2];
    bit            m_dead  [2];
    bit            exp_pulse [2];
    logic [NB-1:0] m_acc, m_mask;
    int            fidx;
    logic          p_heart;
    logic [NB-1:0] p_bul;

    // Drive one pixel; its sprite flags appear on the inputs one cycle later.
    task automatic pix(input int x, input int y, input bit act, input bit h, input logic [NB-1:0] b);
        xx = 10'(x); yy = 10'(y); aactive = act;
        heart_on = p_heart; bullet_on = p_bul;
        p_heart = h; p_bul = b;
        if (h && act) m_acc |= b;
        @(posedge Pclk); #1;
        chk("pulse0", 32'(bus0.hit_pulse), 32'(exp_pulse[0]));
        chk("pulse1", 32'(bus1.hit_pulse), 32'(exp_pulse[1]));
    endtask

    task automatic check_status();
        int  d;
        bit  inv;
        bit  vis;
        for (int i = 0; i < 2; i++) begin
            d   = fidx - m_last[i];
            inv = !m_dead[i] && (d < IFR - 1);
            vis = inv ? (((d / BF) % 2) == 0) : 1'b1;
            if (i == 0) begin
                chk("hp0", 32'(bus0.hp), 32'(m_hp[0]));
                chk("mask0", 32'(bus0.hit_mask), 32'(m_mask));
                chk("inv0", 32'(bus0.invuln), 32'(inv));
                chk("vis0", 32'(bus0.heart_visible), 32'(vis));
                chk("over0", 32'(bus0.game_over), 32'(m_dead[0]));
            end else begin
                chk("hp1", 32'(bus1.hp), 32'(m_hp[1]));
                chk("mask1", 32'(bus1.hit_mask), 32'(m_mask));
                chk("inv1", 32'(bus1.invuln), 32'(inv));
                chk("vis1", 32'(bus1.heart_visible), 32'(vis));
                chk("over1", 32'(bus1.game_over), 32'(m_dead[1]));
            end
        end
    endtask

    task automatic end_frame(input bit h, input logic [NB-1:0] b);
        pix(639, 479, 1'b1, h, b);
        fidx++;
        m_mask = m_acc;
        m_acc  = '0;
        for (int i = 0; i < 2; i++) begin
            exp_pulse[i] = 1'b0;
            if (!m_dead[i] && m_mask != '0 && (fidx - m_last[i] >= IFR)) begin
                m_hp[i]      = (m_hp[i] > DMG) ? m_hp[i] - DMG : 0;
                exp_pulse[i] = 1'b1;
                m_last[i]    = fidx;
                if (m_hp[i] == 0) m_dead[i] = 1'b1;
            end
        end
        pix(645, 479, 1'b0, 1'b0, '0);
        exp_pulse[0] = 1'b0;
        exp_pulse[1] = 1'b0;
        check_status();
    endtask

    task automatic frame(input bit rnd, input bit h300, input logic [NB-1:0] b300,
                         input bit inact, input bit hl, input logic [NB-1:0] bl);
        for (int k = 0; k < 3; k++) begin
            pix(int'($urandom_range(0, 638)), int'($urandom_range(0, 479)),
                1'($urandom_range(0, 3) != 0),
                rnd ? ($urandom_range(0, 7) == 0) : 1'b0,
                NB'($urandom));
        end
        if (h300)  pix(300, 250, 1'b1, 1'b1, b300);
        if (inact) pix(700, 250, 1'b0, 1'b1, '1);
        end_frame(hl, bl);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        xx = '0; yy = '0; aactive = 1'b0; heart_on = 1'b0; bullet_on = '0;
        p_heart = 1'b0; p_bul = '0;
        @(posedge Pclk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m_hp[i] = hp_init[i]; m_last[i] = -1000; m_dead[i] = 1'b0; exp_pulse[i] = 1'b0;
        end
        m_acc = '0; m_mask = '0;
        chk("rst_pulse0", 32'(bus0.hit_pulse), 32'd0);
        check_status();
    endtask

    initial begin
        fidx = 0;
        do_reset();
        repeat (3) frame(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        frame(1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, '0);
        chk("tp_hp17", 32'(bus0.hp), 32'd17);
        chk("tp_mask4", 32'(bus0.hit_mask), 32'b0100);
        repeat (59) frame(1'b0, 1'b1, 4'b0100, 1'b1, 1'b0, '0);
        frame(1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, '0);
        chk("tp_hp14", 32'(bus0.hp), 32'd14);
        chk("tp_over1", 32'(bus1.game_over), 32'd1);
        repeat (59) frame(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        frame(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
        frame(1'b0, 1'b1, 4'b1001, 1'b0, 1'b0, '0);
        chk("tp_hp11", 32'(bus0.hp), 32'd11);
        chk("tp_mask9", 32'(bus0.hit_mask), 32'b1001);
        repeat (10) frame(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        pix(100, 100, 1'b1, 1'b1, '1);
        pix(101, 100, 1'b1, 1'b1, '1);
        do_reset();
        chk("tp_rst_hp", 32'(bus0.hp), 32'd20);
        frame(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        frame(1'b0, 1'b0, '0, 1'b0, 1'b1, 4'b0010);
        chk("tp_last_hp", 32'(bus0.hp), 32'd17);
        repeat (200) frame(1'b1, 1'($urandom_range(0, 5) == 0), NB'($urandom),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0), NB'($urandom));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
